mdu_hilo: RTL and testbench
===========================

// Module: mdu_hilo
// PURPOSE
//  Multi-cycle multiply/divide unit with architectural HI/LO registers for the E stage of the
//  5-stage MIPS pipeline. Generalises the E-stage HI/LO/mfhi/mflo result selection into a
//  sequential block: parametrised width and latencies, busy tracking, flush, mthi/mtlo, and
//  mfhi/mflo read-out feeding the E-stage result mux.
// PARAMETERS
//  WIDTH       32  operand width; HI and LO are WIDTH bits each, product is 2*WIDTH
//  MUL_CYCLES  5   busy cycles for mult/multu (and madd* when enabled); must be >=1
//  DIV_CYCLES  10  busy cycles for div/divu; must be >=1
// PORTS
//  clk      in   1      clock, rising edge
//  reset    in   1      asynchronous, active-low reset
//  valid    in   1      E-stage instruction is live (not bubble/flushed)
//  op       in   4      MDU operation code (mdu_pkg)
//  rs       in   WIDTH  forwarded operand A
//  rt       in   WIDTH  forwarded operand B
//  flush    in   1      abort in-flight op (exception/interrupt)
//  start    out  1      comb: op accepted this cycle = valid & op in {mult*,div*,madd*} & !busy
//  busy     out  1      registered: multi-cycle op in flight
//  hi       out  WIDTH  HI register
//  lo       out  WIDTH  LO register
//  rd_data  out  WIDTH  comb: hi if op==MFHI, lo if op==MFLO, else 0
// BEHAVIOUR
//  - Reset (reset==0, async): busy=0, cnt=0, hi=0, lo=0, pending results=0.
//  - Ops: 0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO,7 MTHI,8 MTLO; 9-12 MADD/MADDU/MSUB/MSUBU.
//  - Accept: on the edge ending a cycle with start=1, compute result into pending hi/lo,
//    cnt<=MUL_CYCLES or DIV_CYCLES, busy<=1.
//  - Busy: each edge cnt<=cnt-1; on the edge where cnt==1, hi/lo<=pending, busy<=0.
//    busy high exactly N cycles; new hi/lo visible on rd_data the cycle busy first reads 0.
//  - Ops arriving while busy are ignored; the hazard unit stalls D when D holds an MDU-class
//    op and (start|busy). MTHI/MTLO (valid, !busy) write hi/lo=rs on the next edge.
//  - MULT: {hi,lo}=signed rs*rt; MULTU unsigned. DIV: lo=quotient (truncate toward 0),
//    hi=remainder (sign of dividend); DIVU unsigned. rs=MIN, rt=-1 (DIV): lo=MIN, hi=0.
//  - Divide by zero: op accepted, busy runs DIV_CYCLES, hi/lo unchanged at completion.
//  - flush: priority over everything except reset; busy<=0, cnt<=0, hi/lo unchanged,
//    pending discarded. flush with start in the same cycle: the op is not accepted.
//  - Completion edge coinciding with a new start: impossible (start requires !busy).
// CONFIGURATION
//  MDU_MADD_EN defined: ops 9-12 legal; {hi,lo} <= {hi,lo} +/- rs*rt (signed for MADD/MSUB,
//  unsigned for MADDU/MSUBU) mod 2^(2*WIDTH); uses MUL_CYCLES; accumulator value sampled at start.
//  Undefined: ops 9-12 decode as NONE (start=0, no state change).
// STRUCTURE
//  mdu_pkg: op code localparams, MDU-class predicate, latency-select function.
//  Sub-module mdu_arith: purely combinational mul/div/madd producing {hi_next,lo_next};
//  mdu_hilo holds counter, busy, pending and HI/LO regs.
// TESTING
//  1 reset low mid-DIV (cnt=4) -> busy=0, hi=lo=0 immediately, no later commit.
//  2 MULT rs=-3 rt=7 -> busy 5 cycles; then hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; MFHI/MFLO read them.
//  3 DIV rs=-7 rt=2 -> after 10 busy cycles lo=-3, hi=-1; DIVU rs=7 rt=0 -> hi/lo unchanged.
//  4 MULT issued, flush at busy cycle 3 -> busy=0 next cycle, hi/lo keep pre-op values.
//  5 MTHI rs=0x1234 then MULTU issued while busy from prior op -> second MULTU ignored, hi=0x1234
//    until first op commits.
//  6 (MDU_MADD_EN) hi=0,lo=10; MADD rs=3 rt=4 -> lo=22; MSUBU rs=1 rt=23 -> {hi,lo}=-1 (all ones).

Source files
------------

// File: rtl/mdu_pkg.sv
// Op codes and decode helpers shared by the multiply/divide unit.
// Define MDU_MADD_EN to enable the multiply-accumulate ops (9-12).
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  // Ops that occupy the unit for multiple cycles.
  function automatic logic is_multi(input logic [3:0] op);
    logic m;
    m = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    m = m || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return m;
  endfunction

  function automatic int op_latency(input logic [3:0] op, input int mul_c, input int div_c);
    return ((op == OP_DIV) || (op == OP_DIVU)) ? div_c : mul_c;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: next {hi,lo} for mul/div (and multiply-accumulate
// when MDU_MADD_EN is defined). Unrecognised ops pass hi/lo through.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  localparam int W2 = 2 * WIDTH;

  logic [W2-1:0]    sprod, uprod;
  logic             sgn, na, nb;
  logic [WIDTH-1:0] ua, ub, ub_nz, uq, ur, q, r;

  // Low 2W bits of the sign-extended product equal the signed product.
  assign sprod = {{WIDTH{rs[WIDTH-1]}}, rs} * {{WIDTH{rt[WIDTH-1]}}, rt};
  assign uprod = {{WIDTH{1'b0}}, rs} * {{WIDTH{1'b0}}, rt};

  // Signed divide on magnitudes; MIN/-1 wraps naturally to lo=MIN, hi=0.
  assign sgn   = (op == OP_DIV);
  assign na    = sgn & rs[WIDTH-1];
  assign nb    = sgn & rt[WIDTH-1];
  assign ua    = na ? -rs : rs;
  assign ub    = nb ? -rt : rt;
  assign ub_nz = (ub == '0) ? WIDTH'(1) : ub;
  assign uq    = ua / ub_nz;
  assign ur    = ua % ub_nz;
  assign q     = (na ^ nb) ? -uq : uq;
  assign r     = na ? -ur : ur;

  always_comb begin
    hi_next = hi;
    lo_next = lo;
    case (op)
      OP_MULT:  {hi_next, lo_next} = sprod;
      OP_MULTU: {hi_next, lo_next} = uprod;
      OP_DIV, OP_DIVU: begin
        if (rt != '0) begin
          lo_next = q;
          hi_next = r;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {hi_next, lo_next} = {hi, lo} + sprod;
      OP_MADDU: {hi_next, lo_next} = {hi, lo} + uprod;
      OP_MSUB:  {hi_next, lo_next} = {hi, lo} - sprod;
      OP_MSUBU: {hi_next, lo_next} = {hi, lo} - uprod;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// E-stage multi-cycle multiply/divide unit with HI/LO registers.
// Optional multiply-accumulate ops are enabled by defining MDU_MADD_EN.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_pend, lo_pend, hi_next, lo_next;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op      (op),
    .rs      (rs),
    .rt      (rt),
    .hi      (hi),
    .lo      (lo),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  assign start = valid & is_multi(op) & ~busy;

  always_comb begin
    rd_data = '0;
    if (op == OP_MFHI)      rd_data = hi;
    else if (op == OP_MFLO) rd_data = lo;
  end

  // Result is computed at accept and held in pending until the latency elapses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy    <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      hi_pend <= '0;
      lo_pend <= '0;
    end else if (flush) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        hi   <= hi_pend;
        lo   <= lo_pend;
        busy <= 1'b0;
      end
    end else if (start) begin
      hi_pend <= hi_next;
      lo_pend <= lo_next;
      cnt     <= CW'(op_latency(op, MUL_CYCLES, DIV_CYCLES));
      busy    <= 1'b1;
    end else if (valid && op == OP_MTHI) begin
      hi <= rs;
    end else if (valid && op == OP_MTLO) begin
      lo <= rs;
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: vector table plus corner sequences,
// with a commit scoreboard fed at issue and drained when busy drops.
module tb_mdu_hilo;
  import mdu_pkg::*;

  localparam int W = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         valid = 1'b0;
  logic [3:0]   op = OP_NONE;
  logic [W-1:0] rs = '0, rt = '0;
  logic         flush = 1'b0;
  logic         start, busy;
  logic [W-1:0] hi, lo, rd_data;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] sb_q[$];
  logic prev_busy = 1'b0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] rs, rt, hi, lo;
    int           cyc;
  } vec_t;
  vec_t tbl[12];

  mdu_hilo #(.WIDTH(W), .MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .rs(rs), .rt(rt),
    .flush(flush), .start(start), .busy(busy), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard drain: a busy 1->0 transition outside reset is a commit.
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (reset && prev_busy && !busy && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("commit_hi", hi, e[2*W-1:W]);
      chk("commit_lo", lo, e[W-1:0]);
    end
    prev_busy = busy;
  end

  task automatic mt(input logic [3:0] o, input logic [W-1:0] v);
    @(negedge clk);
    valid = 1'b1; op = o; rs = v;
    @(negedge clk);
    valid = 1'b0; op = OP_NONE;
  endtask

  task automatic run_op(input string name, input logic [3:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh,
                        input logic [W-1:0] el, input int cyc);
    int n;
    @(negedge clk);
    valid = 1'b1; op = o; rs = a; rt = b;
    #1 chk({name, "_start"}, W'(start), W'(1));
    sb_q.push_back({eh, el});
    @(negedge clk);
    valid = 1'b0; op = OP_NONE;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_cycles"}, W'(n), W'(cyc));
    @(negedge clk);
    op = OP_MFHI;
    #1 chk({name, "_mfhi"}, rd_data, eh);
    op = OP_MFLO;
    #1 chk({name, "_mflo"}, rd_data, el);
    op = OP_NONE;
  endtask

  initial begin
    tbl[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, MC};
    tbl[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
    tbl[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};
    tbl[3]  = '{OP_MULT,  32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MC};
    tbl[4]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    tbl[5]  = '{OP_DIVU,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    tbl[6]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
    tbl[7]  = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, DC};
    tbl[8]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};
    tbl[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'd2,        32'h00000001, 32'h7FFFFFFF, DC};
    tbl[10] = '{OP_DIV,   32'd0,        32'd0,        32'h00000001, 32'h7FFFFFFF, DC};
    tbl[11] = '{OP_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, MC};

    // Reset state
    #2;
    chk("rst_busy", W'(busy), '0);
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    @(negedge clk);
    reset = 1'b1;

    // Async reset in the middle of a divide (cnt=4)
    mt(OP_MTLO, 32'd5);
    chk("mtlo", lo, 32'd5);
    @(negedge clk);
    valid = 1'b1; op = OP_DIVU; rs = 32'd100; rt = 32'd7;
    @(negedge clk);
    valid = 1'b0; op = OP_NONE;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", W'(busy), '0);
    chk("midrst_hi", hi, '0);
    chk("midrst_lo", lo, '0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_nocommit_busy", W'(busy), '0);
    chk("midrst_nocommit_lo", lo, '0);

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].rs, tbl[i].rt,
             tbl[i].hi, tbl[i].lo, tbl[i].cyc);

    // Flush during busy cycle 3: no commit
    @(negedge clk);
    valid = 1'b1; op = OP_MULT; rs = 32'd3; rt = 32'd3;
    @(negedge clk);
    valid = 1'b0; op = OP_NONE;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", W'(busy), '0);
    repeat (8) @(negedge clk);
    chk("flush_busy_late", W'(busy), '0);
    chk("flush_hi", hi, 32'h00000001);
    chk("flush_lo", lo, 32'h23456780);

    // Flush coincident with start: op not accepted
    @(negedge clk);
    valid = 1'b1; op = OP_MULT; rs = 32'd3; rt = 32'd3; flush = 1'b1;
    @(negedge clk);
    valid = 1'b0; op = OP_NONE; flush = 1'b0;
    chk("flushstart_busy", W'(busy), '0);
    repeat (6) @(negedge clk);
    chk("flushstart_lo", lo, 32'h23456780);

    // MTHI, then a MULTU while another is in flight is ignored
    mt(OP_MTHI, 32'h1234);
    chk("mthi", hi, 32'h1234);
    @(negedge clk);
    valid = 1'b1; op = OP_MULTU; rs = 32'd2; rt = 32'd3;
    sb_q.push_back({32'h0, 32'h6});
    @(negedge clk);
    rs = 32'd5; rt = 32'd5;
    #1 chk("busy_start", W'(start), '0);
    @(negedge clk);
    valid = 1'b0; op = OP_NONE;
    chk("busy_hi_hold", hi, 32'h1234);
    begin
      int n;
      n = 1;
      while (busy === 1'b1 && n < 200) begin
        n++;
        @(negedge clk);
      end
      chk("busy_cycles", W'(n), W'(MC));
    end
    chk("ignored_hi", hi, 32'h0);
    chk("ignored_lo", lo, 32'h6);
    repeat (8) @(negedge clk);
    chk("ignored_no2nd_busy", W'(busy), '0);
    chk("ignored_no2nd_lo", lo, 32'h6);

`ifdef MDU_MADD_EN
    mt(OP_MTHI, 32'd0);
    mt(OP_MTLO, 32'd10);
    run_op("madd", OP_MADD, 32'd3, 32'd4, 32'h0, 32'd22, MC);
    run_op("msubu", OP_MSUBU, 32'd1, 32'd23, 32'hFFFFFFFF, 32'hFFFFFFFF, MC);
`else
    @(negedge clk);
    valid = 1'b1; op = OP_MADD; rs = 32'd3; rt = 32'd4;
    #1 chk("madd_off_start", W'(start), '0);
    @(negedge clk);
    valid = 1'b0; op = OP_NONE;
    chk("madd_off_busy", W'(busy), '0);
    chk("madd_off_hi", hi, 32'h0);
    chk("madd_off_lo", lo, 32'h6);
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", W'(sb_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
